// File: rtl/kronos_dmem.sv
// kronos_dmem: single-port word-addressed data memory responder for the core data port.
//   Parameters: DEPTH (words, power of two 16..65536), WAIT_CYCLES (extra response delay, 0..15).
//   Optional:   define KRONOS_DMEM_BOUNDS_EN to add out-of-range detection and the data_err port.
//   Ports:
//     clk          - sole clock, rising edge
//     rstz         - asynchronous active-low reset
//     data_addr    - byte address (bits [1:0] ignored)
//     data_wr_data - write data
//     data_wr_mask - byte-lane write enables
//     data_rd_req  - read request
//     data_wr_req  - write request (wins when both requests are high)
//     data_rd_data - registered read data, held until the next completed read
//     data_gnt     - one-cycle grant completing the transaction
//     data_err     - one-cycle out-of-range flag alongside data_gnt (KRONOS_DMEM_BOUNDS_EN only)
module kronos_dmem #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rstz,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wr_data,
   input  logic [3:0]  data_wr_mask,
   input  logic        data_rd_req,
   input  logic        data_wr_req,
   output logic [31:0] data_rd_data,
   output logic        data_gnt
`ifdef KRONOS_DMEM_BOUNDS_EN
   ,
   output logic        data_err
`endif
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t          state;
   logic [3:0]      cnt;
   logic [AW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic [3:0]      mask_q;
   logic            wr_q;
   logic            oor_q;
   logic            oor;
   logic            access;
   logic            mem_we;
   logic [31:0]     mem [DEPTH];
`ifdef KRONOS_DMEM_BOUNDS_EN
   logic            unused_addr;
   assign oor         = |data_addr[31:AW+2];
   assign unused_addr = ^data_addr[1:0];
`else
   logic            unused_addr;
   assign oor         = 1'b0;
   assign unused_addr = ^{data_addr[31:AW+2], data_addr[1:0], oor_q};
`endif
   // The access happens on the last WAIT cycle; reset forces IDLE, so a
   // pending write is dropped whenever reset arrives before that edge.
   assign access = (state == WAIT) && (cnt == 4'd0);
   assign mem_we = access && wr_q && !oor_q;
   always_ff @(posedge clk) begin
      if (mem_we)
         for (int i = 0; i < 4; i++)
            if (mask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
   end
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         mask_q       <= 4'd0;
         wr_q         <= 1'b0;
         oor_q        <= 1'b0;
         data_gnt     <= 1'b0;
         data_rd_data <= 32'd0;
`ifdef KRONOS_DMEM_BOUNDS_EN
         data_err     <= 1'b0;
`endif
      end else begin
         data_gnt <= 1'b0;
`ifdef KRONOS_DMEM_BOUNDS_EN
         data_err <= 1'b0;
`endif
         case (state)
            IDLE: if (data_rd_req || data_wr_req) begin
               idx_q   <= data_addr[AW+1:2];
               wdata_q <= data_wr_data;
               mask_q  <= data_wr_mask;
               wr_q    <= data_wr_req;
               oor_q   <= oor;
               cnt     <= 4'(WAIT_CYCLES);
               state   <= WAIT;
            end
            WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else begin
               state    <= RESP;
               data_gnt <= 1'b1;
`ifdef KRONOS_DMEM_BOUNDS_EN
               data_err <= oor_q;
`endif
               if (!wr_q) data_rd_data <= oor_q ? 32'd0 : mem[idx_q];
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kronos_dmem.sv
// tb_kronos_dmem: randomized and directed self-checking bench for kronos_dmem against a word-array model.
module tb_kronos_dmem;
   localparam int W     = 1;
   localparam int DEPTH = 1024;
   logic        clk = 1'b0;
   logic        rstz = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  mask = 4'd0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] rdata;
   logic        gnt;
`ifdef KRONOS_DMEM_BOUNDS_EN
   logic        err;
`endif
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [int];
   logic [31:0] exp_rd = 32'd0;
   always #5 clk = ~clk;
   kronos_dmem #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rstz(rstz), .data_addr(addr), .data_wr_data(wdata),
      .data_wr_mask(mask), .data_rd_req(rd), .data_wr_req(wr),
      .data_rd_data(rdata), .data_gnt(gnt)
`ifdef KRONOS_DMEM_BOUNDS_EN
      , .data_err(err)
`endif
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask
   function automatic bit out_of_range(input logic [31:0] a);
`ifdef KRONOS_DMEM_BOUNDS_EN
      return (a >> 2) >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction
   // Issue one request at a negedge; the negedge index at which the grant is
   // seen equals the cycle offset from the request cycle.
   task automatic txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit drop, input string tag);
      int k = 0;
      int idx = int'((a >> 2) % DEPTH);
      bit bad = out_of_range(a);
      logic e_got = 1'b0;
      logic [31:0] v;
      addr = a; wdata = d; mask = m; rd = r; wr = w;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (drop && i == 1) begin rd = 1'b0; wr = 1'b0; end
         if (gnt === 1'b1) begin
            k = i;
`ifdef KRONOS_DMEM_BOUNDS_EN
            e_got = err;
`endif
            break;
         end
      end
      rd = 1'b0; wr = 1'b0;
      chk({tag, " latency"}, k, 2 + W);
`ifdef KRONOS_DMEM_BOUNDS_EN
      chk({tag, " err"}, 32'(e_got), 32'(bad));
`endif
      if (w) begin
         if (!bad) begin
            v = model.exists(idx) ? model[idx] : 32'd0;
            for (int i = 0; i < 4; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
            if (model.exists(idx) || m == 4'hF) model[idx] = v;
         end
      end else exp_rd = bad ? 32'd0 : model[idx];
      @(negedge clk);
      chk({tag, " gnt single"}, 32'(gnt), 32'd0);
      chk({tag, " rdata"}, rdata, exp_rd);
   endtask
   initial begin
      int pos[4];
      int n;
      logic [31:0] a;
      @(negedge clk);
      @(negedge clk);
      chk("reset gnt", 32'(gnt), 32'd0);
      chk("reset rdata", rdata, 32'd0);
`ifdef KRONOS_DMEM_BOUNDS_EN
      chk("reset err", 32'(err), 32'd0);
`endif
      rstz = 1'b1;
      txn(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 0, "wr deadbeef");
      txn(1, 0, 32'h0000_0100, 32'h0, 4'h0, 0, "rd deadbeef");
      chk("deadbeef value", rdata, 32'hDEAD_BEEF);
      txn(0, 1, 32'h0000_0100, 32'h1122_3344, 4'hF, 0, "wr 11223344");
      txn(0, 1, 32'h0000_0102, 32'hAABB_CCDD, 4'b0101, 0, "wr masked");
      txn(1, 0, 32'h0000_0101, 32'h0, 4'h0, 0, "rd masked");
      chk("masked value", rdata, 32'h11BB_33DD);
      txn(0, 1, 32'h0000_0080, 32'h0, 4'hF, 0, "wr clear 0x80");
      txn(1, 1, 32'h0000_0080, 32'h0F0F_0F0F, 4'hF, 0, "rd+wr");
      chk("rd+wr keeps rdata", rdata, 32'h11BB_33DD);
      txn(1, 0, 32'h0000_0080, 32'h0, 4'h0, 0, "rd after rd+wr");
      txn(0, 1, 32'h0000_0080, 32'hFFFF_FFFF, 4'h0, 0, "wr mask0");
      txn(1, 0, 32'h0000_0080, 32'h0, 4'h0, 0, "rd after mask0");
      chk("mask0 value", rdata, 32'h0F0F_0F0F);
      txn(1, 0, 32'h0000_0100, 32'h0, 4'h0, 1, "rd dropped req");
      txn(0, 1, 32'h0000_0104, 32'h1357_9BDF, 4'hF, 1, "wr dropped req");
      txn(1, 0, 32'h0000_0104, 32'h0, 4'h0, 0, "rd after dropped wr");
      // Back-to-back reads with the request held high throughout.
      addr = 32'h0000_0080; rd = 1'b1; n = 0;
      for (int i = 0; i < 4; i++) pos[i] = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (gnt === 1'b1) begin
            pos[n] = i; n++;
            if (n == 4) begin rd = 1'b0; break; end
         end
      end
      rd = 1'b0;
      for (int j = 0; j < 4; j++) chk($sformatf("b2b gnt %0d", j), pos[j], 2 + W + j * (3 + W));
      exp_rd = model[32];
      @(negedge clk);
      chk("b2b rdata", rdata, exp_rd);
      // Reset while a write is waiting.
      txn(0, 1, 32'h0000_0020, 32'h0, 4'hF, 0, "wr word8 zero");
      addr = 32'h0000_0020; wdata = 32'h5555_5555; mask = 4'hF; wr = 1'b1;
      @(negedge clk);
      rstz = 1'b0;
      #1;
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst rdata", rdata, 32'd0);
`ifdef KRONOS_DMEM_BOUNDS_EN
      chk("rst err", 32'(err), 32'd0);
`endif
      @(negedge clk);
      chk("rst hold gnt", 32'(gnt), 32'd0);
      chk("rst hold rdata", rdata, 32'd0);
      wr = 1'b0; rstz = 1'b1; exp_rd = 32'd0;
      txn(1, 0, 32'h0000_0020, 32'h0, 4'h0, 0, "rd word8 after rst");
      chk("word8 value", rdata, 32'h0);
      // Address beyond DEPTH words: error with the macro, alias otherwise.
      txn(0, 1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, "wr word0");
      txn(1, 0, 32'h0000_1000, 32'h0, 4'h0, 0, "rd 0x1000");
`ifdef KRONOS_DMEM_BOUNDS_EN
      chk("oob rdata", rdata, 32'h0);
      txn(0, 1, 32'h0000_1000, 32'h0BAD_0BAD, 4'hF, 0, "wr 0x1000");
      txn(1, 0, 32'h0000_0000, 32'h0, 4'h0, 0, "rd word0 after oob wr");
      chk("word0 untouched", rdata, 32'hCAFE_F00D);
`else
      chk("alias rdata", rdata, 32'hCAFE_F00D);
`endif
      for (int i = 0; i < 8; i++)
         txn(0, 1, 32'(16 + i) << 2, $urandom, 4'hF, 0, "prefill");
      for (int i = 0; i < 40; i++) begin
         int op = $urandom_range(0, 2);
         a = (32'(16 + $urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
`ifndef KRONOS_DMEM_BOUNDS_EN
         a = a | (32'($urandom_range(0, 15)) << 12);
`endif
         txn(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
             $sformatf("rand %0d", i));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/kronos_dmem.md
KRONOS_DMEM -- requirements
Module: kronos_dmem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words; power of two, 16..65536.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra response delay in cycles; range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rstz  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port data_addr  input  32  byte address from requester.
REQ-006 SHALL have port data_wr_data  input  32  write data.
REQ-007 SHALL have port data_wr_mask  input  4  byte-lane write enables; bit i covers bits 8i+7:8i.
REQ-008 SHALL have port data_rd_req  input  1  read request.
REQ-009 SHALL have port data_wr_req  input  1  write request.
REQ-010 SHALL have port data_rd_data  output  32  read data; registered.
REQ-011 SHALL have port data_gnt  output  1  single-cycle grant; completes the transaction.
REQ-012 SHALL have port data_err  output  1  single-cycle out-of-range flag, coincident with data_gnt; present only under KRONOS_DMEM_BOUNDS_EN.

Function
REQ-013 SHALL act as the responder for the core data port: requester holds req, addr, wr_data and wr_mask stable from first assertion until it samples data_gnt.
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one transaction in flight at a time.
REQ-015 IDLE: on rd_req or wr_req high, latch addr/data/mask/op, load wait counter with WAIT_CYCLES, go to WAIT.
REQ-016 WAIT: counter nonzero -> decrement and stay; counter zero -> perform memory access, go to RESP.
REQ-017 RESP: data_gnt=1 for exactly this cycle; requests ignored; next state IDLE unconditionally.
REQ-018 Latency: request first high in cycle T -> data_gnt high in cycle T+2+WAIT_CYCLES; back-to-back throughput = one transaction per 3+WAIT_CYCLES cycles.
REQ-019 Word index = data_addr[log2(DEPTH)+1:2]; data_addr[1:0] ignored.
REQ-020 Write: on WAIT->RESP, update only lanes whose mask bit is 1; mask 4'b0000 writes nothing but is still granted.
REQ-021 Read: on WAIT->RESP, load data_rd_data with the addressed word; value held until the next read completes; writes do not change it.
REQ-022 rd_req and wr_req both high in IDLE: treat as write; data_rd_data unchanged.
REQ-023 Request deasserted during WAIT: transaction still completes and is granted.
REQ-024 Memory contents SHALL NOT be initialised or cleared by reset.

Reset
REQ-025 rstz low SHALL immediately force state IDLE, counter 0, data_gnt 0, data_rd_data 0, data_err 0.
REQ-026 Reset during WAIT SHALL discard the pending access; no memory write occurs.
REQ-027 First request SHALL be accepted in the first cycle after rstz deasserts.

Configuration
REQ-028 Macro KRONOS_DMEM_BOUNDS_EN defined: addresses with any bit of data_addr[31:log2(DEPTH)+2] set are out of range; they are granted normally, writes dropped, data_rd_data loaded with 0, data_err=1 in the RESP cycle.
REQ-029 KRONOS_DMEM_BOUNDS_EN undefined: no data_err port, upper address bits ignored, accesses alias modulo DEPTH words.

Verification
REQ-030 WAIT_CYCLES=1: write 0x0000_0100 <- 0xDEAD_BEEF, mask 4'hF; rd_req high in cycle 10 -> data_gnt only in cycle 13 -> data_rd_data=0xDEAD_BEEF from cycle 14.
REQ-031 Word 0x40 = 0x1122_3344; write 0xAABB_CCDD mask 4'b0101 -> read returns 0x11BB_33DD.
REQ-032 WAIT_CYCLES=0, rd_req held continuously for 4 reads -> data_gnt high in cycles T+2, T+5, T+8, T+11.
REQ-033 rstz pulsed low one cycle after accepting a write of 0x5555_5555 to word 8 (prior 0x0) -> no data_gnt, word 8 reads 0x0, outputs 0 during reset.
REQ-034 DEPTH=1024 with macro: read 0x0000_1000 -> data_gnt and data_err high together, data_rd_data=0; without macro: same read returns word 0 contents, no error.
REQ-035 rd_req and wr_req both high with 0x0F0F_0F0F, mask 4'hF -> memory written, data_rd_data unchanged, single grant.
